// File: rtl/ili_seq_ctrl_pkg.sv
// Shared definitions for the ILI9341 sequencer slice.
// Holds logic-level constants, the sequencer state encoding, the layout of
// one command-table entry and small helpers that build table entries.
package pkg_ili9341;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;
    localparam logic ON   = 1'b1;
    localparam logic OFF  = 1'b0;

    // Native byte width of the ILI9341 command table.
    localparam int DW_DEF = 8;
    localparam logic [DW_DEF-1:0] NO_DATA = 8'h00;

    // Bit positions inside one table entry.
    localparam int ENT_DLY = DW_DEF + 1;
    localparam int ENT_DC  = DW_DEF;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RST_HI    = 4'd1,
        RST_LO    = 4'd2,
        RST_REL   = 4'd3,
        FETCH     = 4'd4,
        DECODE    = 4'd5,
        ISSUE     = 4'd6,
        WAIT_SENT = 4'd7,
        GAP       = 4'd8,
        DELAY     = 4'd9,
        FINISH    = 4'd10
    } seq_state_t;

    typedef struct packed {
        logic              dly;
        logic              dc;
        logic [DW_DEF-1:0] dat;
    } ili_entry_t;

    function automatic ili_entry_t ent_cmd(input logic [DW_DEF-1:0] b);
        return '{dly: 1'b0, dc: 1'b0, dat: b};
    endfunction

    function automatic ili_entry_t ent_dat(input logic [DW_DEF-1:0] b);
        return '{dly: 1'b0, dc: 1'b1, dat: b};
    endfunction

    // Delay marker: dat carries the tick count, dc is don't-care.
    function automatic ili_entry_t ent_dly(input logic [DW_DEF-1:0] ticks);
        return '{dly: 1'b1, dc: 1'b0, dat: ticks};
    endfunction

endpackage

// File: rtl/ili_cmd_rom.sv
// Synchronous ROM holding the ILI9341 power-up table (8-bit entries).
// Ports: clk, rst (async active-low), addr (entry index),
//        data (registered entry, one-cycle latency: {dly, dc, byte}).
// Delay ticks assume one tick per millisecond at the sequencer's DLY_UNIT.
module ili_cmd_rom
    import pkg_ili9341::*;
#(
    parameter  int DW        = 8,
    parameter  int N_ENTRIES = 47,
    localparam int AW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [DW+1:0] data
);

    logic [DW+1:0] data_r;
    ili_entry_t    ent_s;

    function automatic ili_entry_t rom_entry(input logic [AW-1:0] a);
        ili_entry_t e;
        logic [5:0] i;
        i = 6'(a);
        e = ent_dly(NO_DATA);
        if ((int'(a) < N_ENTRIES) && (int'(a) < 47)) begin
            case (i)
                6'd0:  e = ent_cmd(8'h01);   6'd1:  e = ent_dly(8'd5);
                6'd2:  e = ent_cmd(8'h28);   6'd3:  e = ent_cmd(8'hC0);
                6'd4:  e = ent_dat(8'h23);   6'd5:  e = ent_cmd(8'hC1);
                6'd6:  e = ent_dat(8'h10);   6'd7:  e = ent_cmd(8'hC5);
                6'd8:  e = ent_dat(8'h3E);   6'd9:  e = ent_dat(8'h28);
                6'd10: e = ent_cmd(8'hC7);   6'd11: e = ent_dat(8'h86);
                6'd12: e = ent_cmd(8'h36);   6'd13: e = ent_dat(8'h48);
                6'd14: e = ent_cmd(8'h3A);   6'd15: e = ent_dat(8'h55);
                6'd16: e = ent_cmd(8'hB1);   6'd17: e = ent_dat(8'h00);
                6'd18: e = ent_dat(8'h18);   6'd19: e = ent_cmd(8'hB6);
                6'd20: e = ent_dat(8'h08);   6'd21: e = ent_dat(8'h82);
                6'd22: e = ent_dat(8'h27);   6'd23: e = ent_cmd(8'hF2);
                6'd24: e = ent_dat(8'h00);   6'd25: e = ent_cmd(8'h26);
                6'd26: e = ent_dat(8'h01);   6'd27: e = ent_cmd(8'h2A);
                6'd28: e = ent_dat(8'h00);   6'd29: e = ent_dat(8'h00);
                6'd30: e = ent_dat(8'h00);   6'd31: e = ent_dat(8'hEF);
                6'd32: e = ent_cmd(8'h2B);   6'd33: e = ent_dat(8'h00);
                6'd34: e = ent_dat(8'h00);   6'd35: e = ent_dat(8'h01);
                6'd36: e = ent_dat(8'h3F);   6'd37: e = ent_cmd(8'h11);
                6'd38: e = ent_dly(8'd120);  6'd39: e = ent_cmd(8'h29);
                6'd40: e = ent_dly(8'd20);   6'd41: e = ent_cmd(8'h13);
                6'd42: e = ent_cmd(8'h20);   6'd43: e = ent_cmd(8'h38);
                6'd44: e = ent_cmd(8'h34);   6'd45: e = ent_cmd(8'h2C);
                6'd46: e = ent_dly(8'd0);
                default: e = ent_dly(NO_DATA);
            endcase
        end else begin
            e = ent_dly(NO_DATA);
        end
        return e;
    endfunction

    assign ent_s = rom_entry(addr);
    assign data  = data_r;

    // Registered table read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= {(DW+2){1'b0}};
        end else begin
            data_r[ENT_DLY]  <= ent_s.dly;
            data_r[ENT_DC]   <= ent_s.dc;
            data_r[DW-1:0]   <= DW'(ent_s.dat);
        end
    end

endmodule

// File: rtl/ili_seq_ctrl.sv
// Table-driven ILI9341 power-up / command sequencer.
// Ports: clk, rst (async active-low), start (begin when idle), sent (byte
// shifted out), rom_addr/rom_data (external sync ROM, 1-cycle latency),
// cs/dc/reset/data/send towards panel and serializer, busy/done status.
module ili_seq_ctrl
    import pkg_ili9341::*;
#(
    parameter  int DW        = 8,
    parameter  int N_ENTRIES = 47,
    parameter  int RST_CYC   = 15,
    parameter  int GAP_CYC   = 8,
    parameter  int DLY_UNIT  = 1000,
    localparam int AW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sent,
    output logic [AW-1:0] rom_addr,
    input  logic [DW+1:0] rom_data,
    output logic          cs,
    output logic          dc,
    output logic          reset,
    output logic [DW-1:0] data,
    output logic          send,
    output logic          busy,
    output logic          done
);

    // Wide enough for the largest tick count times the tick length.
    localparam int DCW  = $clog2((2**DW - 1) * DLY_UNIT + 1);
    localparam int CMAX = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [AW-1:0]  LAST     = AW'(N_ENTRIES - 1);
    localparam logic [CW-1:0]  RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [DCW-1:0] UNIT     = DCW'(DLY_UNIT);

    seq_state_t     state_r;
    logic [CW-1:0]  cnt_r;
    logic [DCW-1:0] dcnt_r;
    logic [AW-1:0]  rom_addr_r;
    logic           cs_r, dc_r, reset_r, send_r, busy_r, done_r;
    logic [DW-1:0]  data_r;

    logic           ent_dly_s, ent_dc_s, adv_s, last_s;
    logic [DW-1:0]  ent_val_s;
    logic [DCW-1:0] ticks_s;

    assign ent_dly_s = rom_data[DW+1];
    assign ent_dc_s  = rom_data[DW];
    assign ent_val_s = rom_data[DW-1:0];
    assign ticks_s   = DCW'(ent_val_s) * UNIT;
    assign last_s    = (rom_addr_r == LAST);

    // Current entry is finished: zero-tick delay, end of gap or end of delay.
    assign adv_s = ((state_r == DECODE) && ent_dly_s && (ent_val_s == {DW{1'b0}}))
                || ((state_r == GAP) && (cnt_r == GAP_LAST))
                || ((state_r == DELAY) && (dcnt_r == DCW'(1)));

    assign rom_addr = rom_addr_r;
    assign cs       = cs_r;
    assign dc       = dc_r;
    assign reset    = reset_r;
    assign data     = data_r;
    assign send     = send_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Sequencer FSM; outputs are set on entry to the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            dcnt_r     <= {DCW{1'b0}};
            rom_addr_r <= {AW{1'b0}};
            cs_r       <= HIGH;
            dc_r       <= HIGH;
            reset_r    <= HIGH;
            data_r     <= DW'(NO_DATA);
            send_r     <= LOW;
            busy_r     <= OFF;
            done_r     <= OFF;
        end else if (adv_s) begin
            if (last_s) begin
                state_r    <= FINISH;
                cs_r       <= HIGH;
                busy_r     <= OFF;
                done_r     <= ON;
                rom_addr_r <= {AW{1'b0}};
            end else begin
                state_r    <= FETCH;
                rom_addr_r <= rom_addr_r + AW'(1);
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= RST_HI;
                        busy_r     <= ON;
                        done_r     <= OFF;
                        rom_addr_r <= {AW{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                    end
                end
                RST_HI: begin
                    if (cnt_r == RST_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        reset_r <= LOW;
                        state_r <= RST_LO;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RST_LO: begin
                    if (cnt_r == RST_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        reset_r <= HIGH;
                        state_r <= RST_REL;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RST_REL: begin
                    if (cnt_r == RST_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        cs_r    <= LOW;
                        state_r <= FETCH;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                FETCH: state_r <= DECODE;
                DECODE: begin
                    // Zero-tick delays never reach here; adv_s takes them.
                    if (ent_dly_s) begin
                        dcnt_r  <= ticks_s;
                        state_r <= DELAY;
                    end else begin
                        data_r  <= ent_val_s;
                        dc_r    <= ent_dc_s;
                        send_r  <= HIGH;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    send_r  <= LOW;
                    state_r <= WAIT_SENT;
                end
                WAIT_SENT: begin
                    if (sent) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= GAP;
                    end
                end
                GAP:    cnt_r  <= cnt_r + CW'(1);
                DELAY:  dcnt_r <= dcnt_r - DCW'(1);
                FINISH: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ili_seq_ctrl.sv
// Randomized scoreboard bench for ili_seq_ctrl with a small serializer model.
module tb_ili_seq_ctrl;

    localparam int DW = 8;
    localparam int N  = 12;
    localparam int R  = 4;
    localparam int G  = 2;
    localparam int U  = 10;

    logic       clk = 1'b0;
    logic       rst, start, sent;
    logic [3:0] rom_addr;
    logic [9:0] rom_data;
    logic       cs, dc, panel_reset, send, busy, done;
    logic [7:0] data;

    logic [5:0] r_addr;
    logic [9:0] r_data;

    ili_seq_ctrl #(.DW(DW), .N_ENTRIES(N), .RST_CYC(R), .GAP_CYC(G), .DLY_UNIT(U)) dut (
        .clk(clk), .rst(rst), .start(start), .sent(sent),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cs(cs), .dc(dc), .reset(panel_reset), .data(data),
        .send(send), .busy(busy), .done(done)
    );

    ili_cmd_rom #(.DW(8), .N_ENTRIES(47)) u_rom (
        .clk(clk), .rst(rst), .addr(r_addr), .data(r_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural command table seen by the DUT, 1-cycle read latency.
    logic [9:0] tbl [N];
    always @(posedge clk) rom_data <= tbl[rom_addr];

    typedef struct {
        bit         is_end;
        bit         from_start;
        logic       dc;
        logic [7:0] data;
        int         off;
    } item_t;

    item_t exp_q[$];
    item_t plan[$];
    int    checks = 0;
    int    errors = 0;
    int    start_cyc = 0;
    int    sent_cyc = 0;
    bit    abort_mode = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected transactions from the table: a byte entry costs fetch+decode
    // before its send, a delay entry costs 2 + D*U cycles, and after every
    // sent the gap plus one cycle passes before the next fetch.
    task automatic build_plan();
        int  acc;
        bit  fs;
        plan.delete();
        acc = 3 * R + 1;
        fs  = 1'b1;
        for (int i = 0; i < N; i++) begin
            logic [9:0] e;
            e = tbl[i];
            if (e[9]) begin
                acc += 2 + int'(e[7:0]) * U;
            end else begin
                plan.push_back('{is_end: 1'b0, from_start: fs, dc: e[8], data: e[7:0], off: acc + 2});
                acc = G + 1;
                fs  = 1'b0;
            end
        end
        plan.push_back('{is_end: 1'b1, from_start: fs, dc: 1'b0, data: 8'h00, off: acc});
    endtask

    task automatic fill_random(input int from);
        for (int i = from; i < N; i++) begin
            if ($urandom_range(0, 3) == 0)
                tbl[i] = {2'b10, 8'($urandom_range(0, 3))};
            else
                tbl[i] = {1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
        end
    endtask

    task automatic load_directed();
        tbl[0] = 10'h011;   // command 0x11
        tbl[1] = 10'h1A5;   // data 0xA5
        tbl[2] = 10'h203;   // delay 3 ticks
        tbl[3] = 10'h200;   // delay 0 ticks
        tbl[4] = 10'h029;   // command 0x29
        fill_random(5);
    endtask

    // Start a sequence, check the reset pulse shape, optionally run to done.
    task automatic run_seq(input bit full);
        int  n;
        bit  fin;
        build_plan();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        if (full) begin
            foreach (plan[i]) exp_q.push_back(plan[i]);
        end else begin
            exp_q.push_back(plan[0]);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 3 * R + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("busy_on_start", busy, 1);
                chk("done_cleared", done, 0);
            end
            chk("reset_phase", panel_reset, (i > R && i <= 2 * R) ? 0 : 1);
            chk("cs_phase", cs, (i == 3 * R + 1) ? 0 : 1);
            chk("no_early_send", send, 0);
        end
        if (full) begin
            fin = 1'b0;
            for (n = 0; n < 4000 && !fin; n++) begin
                @(posedge clk); #1;
                if (done) begin
                    fin = 1'b1;
                end else begin
                    chk("cs_low_busy", cs, 0);
                    start = busy && ($urandom_range(0, 15) == 0);
                end
            end
            start = 1'b0;
            if (!fin) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got done=0 expected done=1 within 4000 cycles");
            end
            @(negedge clk); #1;
            chk("queue_drained", exp_q.size(), 0);
            chk("end_done", done, 1);
            chk("end_cs", cs, 1);
            chk("end_busy", busy, 0);
            chk("end_addr", rom_addr, 0);
            exp_q.delete();
            repeat (3) @(posedge clk);
        end
    endtask

    // Serializer model: answers each send 1..6 cycles later, sometimes
    // adds a stray sent pulse during the following gap.
    initial begin
        int k;
        bit spur;
        sent = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && send && !abort_mode) begin
                k    = $urandom_range(1, 6);
                spur = 1'($urandom_range(0, 1));
                repeat (k) @(posedge clk);
                #1 sent = 1'b1;
                sent_cyc = cyc;
                @(posedge clk); #1 sent = spur;
                @(posedge clk); #1 sent = 1'b0;
            end
        end
    end

    // Monitor: compare every send and every done rising edge to the queue.
    initial begin
        item_t it;
        int    base;
        bit    done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && send) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: got data=%0h expected no send", data);
                end else begin
                    it   = exp_q.pop_front();
                    base = it.from_start ? start_cyc : sent_cyc;
                    chk("send_kind", it.is_end, 0);
                    chk("send_data", data, it.data);
                    chk("send_dc", dc, it.dc);
                    chk("send_time", cyc - base, it.off);
                    chk("send_cs", cs, 0);
                end
            end
            if (rst && done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected busy");
                end else begin
                    it   = exp_q.pop_front();
                    base = it.from_start ? start_cyc : sent_cyc;
                    chk("finish_kind", it.is_end, 1);
                    chk("finish_time", cyc - base, it.off);
                    chk("finish_busy", busy, 0);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        r_addr = 6'd0;
        load_directed();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", cs, 1);
        chk("rst_dc", dc, 1);
        chk("rst_reset", panel_reset, 1);
        chk("rst_data", data, 0);
        chk("rst_send", send, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 1'b1;

        // Spot checks of the shipped init table.
        r_addr = 6'd0;  @(posedge clk); #1; chk("rom_swreset", r_data, 10'h001);
        r_addr = 6'd13; @(posedge clk); #1; chk("rom_madctl_data", r_data, 10'h148);
        r_addr = 6'd37; @(posedge clk); #1; chk("rom_sleep_out", r_data, 10'h011);
        r_addr = 6'd38; @(posedge clk); #1; chk("rom_sleep_delay", r_data, {2'b10, 8'd120});

        // No auto-start out of reset.
        repeat (5) @(posedge clk); #1;
        chk("idle_no_autostart", busy, 0);

        run_seq(1'b1);
        for (int r = 0; r < 6; r++) begin
            fill_random(0);
            run_seq(1'b1);
        end

        // Abort in WAIT_SENT: first send goes out, the serializer stays silent.
        load_directed();
        abort_mode = 1'b1;
        run_seq(1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_cs", cs, 1);
        chk("abort_dc", dc, 1);
        chk("abort_reset", panel_reset, 1);
        chk("abort_data", data, 0);
        chk("abort_send", send, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_queue", exp_q.size(), 0);
        @(posedge clk); #2 rst = 1'b1;
        abort_mode = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("post_abort_idle", busy, 0);
        chk("post_abort_cs", cs, 1);

        // Replay from entry 0 after the abort.
        run_seq(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
